alu_muldiv: RTL

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// Integer ALU with an optional iterative multiply/divide unit (RV32I/RV32M funct3 encoding).
// Define ALU_MULDIV_EN to build the multiply/divide unit; otherwise M-group requests return ILLEGAL.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [2:0]       funct3,
    input  logic             sub,
    input  logic             m_ext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             illegal
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_q;
    logic             accept;

    assign in_ready  = rst_n && (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out       = out_q;

    function automatic logic [WIDTH-1:0] base_op(input logic [2:0] f, input logic s,
                                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [SH_W-1:0] sh;
        logic            lt;
        sh = b[SH_W-1:0];
        lt = 1'b0;
        base_op = '0;
        case (f)
            3'b000: base_op = s ? (a - b) : (a + b);
            3'b001: base_op = a << sh;
            3'b010: begin
                lt = ($signed(a) < $signed(b));
                base_op = {{(WIDTH-1){1'b0}}, lt};
            end
            3'b011: begin
                lt = (a < b);
                base_op = {{(WIDTH-1){1'b0}}, lt};
            end
            3'b100: base_op = a ^ b;
            3'b101: base_op = s ? $unsigned($signed(a) >>> sh) : (a >> sh);
            3'b110: base_op = a | b;
            default: base_op = a & b;
        endcase
    endfunction

`ifdef ALU_MULDIV_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // acc_hi/acc_lo hold {high,low} product for multiply and {remainder,quotient} for divide
    logic [WIDTH-1:0]   acc_hi, acc_lo, opb;
    logic [2:0]         op_q;
    logic               neg_p, neg_r;
    logic [CNT_W-1:0]   cnt;

    logic               sa, sb, a_neg, b_neg, div_zero, div_ovf;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum, r_sh, diff;
    logic [WIDTH-1:0]   hi_n, lo_n, res_fin;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        sa       = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sb       = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = sa && in0[WIDTH-1];
        b_neg    = sb && in1[WIDTH-1];
        a_mag    = a_neg ? neg_w(in0) : in0;
        b_mag    = b_neg ? neg_w(in1) : in1;
        div_zero = funct3[2] && (in1 == '0);
        div_ovf  = funct3[2] && !funct3[0] && (in0 == MOST_NEG) && (in1 == '1);
    end

    always_comb begin
        sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        r_sh = {acc_hi, acc_lo[WIDTH-1]};
        diff = r_sh - {1'b0, opb};
        if (op_q[2]) begin
            hi_n = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_n = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], acc_lo[WIDTH-1:1]};
        end
        prod = {hi_n, lo_n};
        if (neg_p)
            prod = ~prod + (2*WIDTH)'(1);
        if (op_q[2])
            res_fin = op_q[1] ? (neg_r ? neg_w(hi_n) : hi_n) : (neg_p ? neg_w(lo_n) : lo_n);
        else
            res_fin = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

    assign illegal = 1'b0;
`else
    logic illegal_q;
    assign illegal = illegal_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_q       <= '0;
`ifdef ALU_MULDIV_EN
            acc_hi      <= '0;
            acc_lo      <= '0;
            opb         <= '0;
            op_q        <= '0;
            neg_p       <= 1'b0;
            neg_r       <= 1'b0;
            cnt         <= '0;
`else
            illegal_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!m_ext) begin
                            out_q       <= base_op(funct3, sub, in0, in1);
                            out_valid_q <= 1'b1;
                            state       <= DONE;
`ifndef ALU_MULDIV_EN
                            illegal_q   <= 1'b0;
`endif
                        end else begin
`ifdef ALU_MULDIV_EN
                            cnt <= '0;
                            if (div_zero) begin
                                out_q       <= funct3[1] ? in0 : '1;
                                out_valid_q <= 1'b1;
                                state       <= DONE;
                            end else if (div_ovf) begin
                                out_q       <= funct3[1] ? '0 : in0;
                                out_valid_q <= 1'b1;
                                state       <= DONE;
                            end else begin
                                acc_hi <= '0;
                                acc_lo <= funct3[2] ? a_mag : b_mag;
                                opb    <= funct3[2] ? b_mag : a_mag;
                                op_q   <= funct3;
                                neg_p  <= a_neg ^ b_neg;
                                neg_r  <= a_neg;
                                state  <= BUSY;
                            end
`else
                            out_q       <= '0;
                            illegal_q   <= 1'b1;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
`endif
                        end
                    end
                end
`ifdef ALU_MULDIV_EN
                // one multiply/divide bit per cycle; sign correction folded into the last step
                BUSY: begin
                    acc_hi <= hi_n;
                    acc_lo <= lo_n;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        out_q       <= res_fin;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
